// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default operand/index widths, opcode width and the
// operand-fetch occupancy states.
package cpu_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 3;
    localparam int OP_WIDTH       = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HELD  = 2'd2
    } of_state_e;

endpackage

// File: rtl/operand_bypass_mux.sv
// Per-operand select: compares a register index against the write-back port
// and substitutes the write-back data on a match.
module operand_bypass_mux
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_idx,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [ADDR_WIDTH-1:0] sel_idx,
    input  logic [DATA_WIDTH-1:0] base_data,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] out_data
);

    assign hit      = wb_en && (wb_idx == sel_idx);
    assign out_data = hit ? wb_data : base_data;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: one-entry output register with hold, flush, load-use
// interlock and write-back forwarding (OPERAND_FETCH_BYPASS_EN enables accept-time bypass).
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  validIn,
    output logic                  readyOut,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic                  regWriteIn,
    input  logic                  memReadIn,
    input  logic [OP_WIDTH-1:0]   opIn,
    input  logic [DATA_WIDTH-1:0] immIn,
    output logic [ADDR_WIDTH-1:0] readRegister1,
    output logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic [DATA_WIDTH-1:0] readData1,
    input  logic [DATA_WIDTH-1:0] readData2,
    input  logic                  wbRegWrite,
    input  logic [ADDR_WIDTH-1:0] wbRegister,
    input  logic [DATA_WIDTH-1:0] wbData,
    input  logic                  stallIn,
    input  logic                  flush,
    output logic                  validOut,
    output logic                  regWriteOut,
    output logic                  memReadOut,
    output logic [ADDR_WIDTH-1:0] rdOut,
    output logic [ADDR_WIDTH-1:0] rs1Out,
    output logic [ADDR_WIDTH-1:0] rs2Out,
    output logic [OP_WIDTH-1:0]   opOut,
    output logic [DATA_WIDTH-1:0] operandA,
    output logic [DATA_WIDTH-1:0] operandB,
    output logic [DATA_WIDTH-1:0] immOut
);

    of_state_e               state_q, state_d, phase;
    logic                    reg_write_q, reg_write_d;
    logic                    mem_read_q, mem_read_d;
    logic [ADDR_WIDTH-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [OP_WIDTH-1:0]     op_q, op_d;
    logic [DATA_WIDTH-1:0]   operand_a_q, operand_a_d, operand_b_q, operand_b_d;
    logic [DATA_WIDTH-1:0]   imm_q, imm_d;

    logic                    held, load_use, raw_stall, ready, accept;
    logic                    hit_a, hit_b;
    logic [ADDR_WIDTH-1:0]   sel_a, sel_b;
    logic [DATA_WIDTH-1:0]   base_a, base_b, mux_a, mux_b;

    assign readRegister1 = rs1;
    assign readRegister2 = rs2;

    assign held = (state_q == ST_FULL) && stallIn;
    assign phase = (state_q == ST_EMPTY) ? ST_EMPTY : (stallIn ? ST_HELD : ST_FULL);

    // While held the muxes refresh the stored operands; otherwise they select
    // the incoming operands, so one pair serves both forwarding paths.
    assign sel_a  = held ? rs1_q : rs1;
    assign sel_b  = held ? rs2_q : rs2;
    assign base_a = held ? operand_a_q : readData1;
    assign base_b = held ? operand_b_q : readData2;

    operand_bypass_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux_a (
        .wb_en(wbRegWrite), .wb_idx(wbRegister), .wb_data(wbData),
        .sel_idx(sel_a), .base_data(base_a), .hit(hit_a), .out_data(mux_a)
    );

    operand_bypass_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux_b (
        .wb_en(wbRegWrite), .wb_idx(wbRegister), .wb_data(wbData),
        .sel_idx(sel_b), .base_data(base_b), .hit(hit_b), .out_data(mux_b)
    );

    always_comb begin
        load_use = (state_q == ST_FULL) && mem_read_q && reg_write_q && validIn &&
                   ((rd_q == rs1) || (rd_q == rs2));
`ifdef OPERAND_FETCH_BYPASS_EN
        raw_stall = 1'b0;
`else
        // Without bypass the register file write lands at this edge, so the
        // read data is only correct one cycle later.
        raw_stall = validIn && (hit_a || hit_b);
`endif
        ready  = resetN && (flush || !(held || load_use || raw_stall));
        accept = validIn && ready && !flush;
    end

    always_comb begin
        state_d     = state_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        op_d        = op_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        imm_d       = imm_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (phase)
                ST_HELD: begin
                    operand_a_d = mux_a;
                    operand_b_d = mux_b;
                end
                default: begin
                    if (accept) begin
                        state_d     = ST_FULL;
                        reg_write_d = regWriteIn;
                        mem_read_d  = memReadIn;
                        rd_d        = rd;
                        rs1_d       = rs1;
                        rs2_d       = rs2;
                        op_d        = opIn;
                        operand_a_d = mux_a;
                        operand_b_d = mux_b;
                        imm_d       = immIn;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q     <= ST_EMPTY;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            op_q        <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            imm_q       <= '0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            op_q        <= op_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            imm_q       <= imm_d;
        end
    end

    assign readyOut    = ready;
    assign validOut    = (state_q == ST_FULL);
    assign regWriteOut = reg_write_q;
    assign memReadOut  = mem_read_q;
    assign rdOut       = rd_q;
    assign rs1Out      = rs1_q;
    assign rs2Out      = rs2_q;
    assign opOut       = op_q;
    assign operandA    = operand_a_q;
    assign operandB    = operand_b_q;
    assign immOut      = imm_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a behavioural register file on the
// read/write-back ports.
module tb_operand_fetch;

    typedef struct packed {
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [3:0] op;
        logic [7:0] imm;
        logic [7:0] a;
        logic [7:0] b;
        logic       regw;
        logic       memr;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN, validIn, readyOut;
    logic [2:0] rs1, rs2, rd, readRegister1, readRegister2;
    logic       regWriteIn, memReadIn;
    logic [3:0] opIn, opOut;
    logic [7:0] immIn, readData1, readData2, wbData;
    logic       wbRegWrite, stallIn, flush;
    logic [2:0] wbRegister, rdOut, rs1Out, rs2Out;
    logic       validOut, regWriteOut, memReadOut;
    logic [7:0] operandA, operandB, immOut;

    logic [7:0] rf [8];
    exp_t       exp_q [$];
    exp_t       mon_e, mon_a;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clock(clk), .resetN(resetN), .validIn(validIn), .readyOut(readyOut),
        .rs1(rs1), .rs2(rs2), .rd(rd), .regWriteIn(regWriteIn), .memReadIn(memReadIn),
        .opIn(opIn), .immIn(immIn), .readRegister1(readRegister1), .readRegister2(readRegister2),
        .readData1(readData1), .readData2(readData2), .wbRegWrite(wbRegWrite),
        .wbRegister(wbRegister), .wbData(wbData), .stallIn(stallIn), .flush(flush),
        .validOut(validOut), .regWriteOut(regWriteOut), .memReadOut(memReadOut),
        .rdOut(rdOut), .rs1Out(rs1Out), .rs2Out(rs2Out), .opOut(opOut),
        .operandA(operandA), .operandB(operandB), .immOut(immOut)
    );

    // Register file: contents 0x00,0x11,0x15,0x33,0x44,0x3A,0x66,0x77 after reset.
    always @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'(i * 17);
            rf[2] <= 8'h15;
            rf[5] <= 8'h3A;
        end else if (wbRegWrite) begin
            rf[wbRegister] <= wbData;
        end
    end
    assign readData1 = rf[readRegister1];
    assign readData2 = rf[readRegister2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] d,
                         input logic [3:0] op, input logic [7:0] imm, input logic rw,
                         input logic mr);
        validIn = 1'b1; rs1 = r1; rs2 = r2; rd = d; opIn = op; immIn = imm;
        regWriteIn = rw; memReadIn = mr;
    endtask

    task automatic expect_out(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e = '{rd: rd, rs1: rs1, rs2: rs2, op: opIn, imm: immIn, a: a, b: b,
              regw: regWriteIn, memr: memReadIn};
        exp_q.push_back(e);
    endtask

    // Monitor: an instruction leaves the stage when validOut && !stallIn.
    always @(negedge clk) begin
        if (resetN === 1'b1 && validOut === 1'b1 && stallIn === 1'b0) begin
            mon_a = '{rd: rdOut, rs1: rs1Out, rs2: rs2Out, op: opOut, imm: immOut,
                      a: operandA, b: operandB, regw: regWriteOut, memr: memReadOut};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %h expected no instruction", mon_a);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL out_fields: got %h expected %h", mon_a, mon_e);
                end
            end
        end
    end

    initial begin
        resetN = 1'b0; validIn = 1'b1; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd3;
        regWriteIn = 1'b1; memReadIn = 1'b0; opIn = 4'h1; immIn = 8'h5A;
        wbRegWrite = 1'b0; wbRegister = '0; wbData = '0; stallIn = 1'b0; flush = 1'b0;
        tick();
        tick();
        chk("reset_ready", 32'(readyOut), 32'd0);
        chk("reset_valid", 32'(validOut), 32'd0);
        chk("reset_fields", 32'({operandA, operandB, immOut, rdOut}), 32'd0);
        resetN = 1'b1; validIn = 1'b0;
        tick();

        // Basic accept and one-cycle latency
        issue(3'd2, 3'd5, 3'd1, 4'h3, 8'h44, 1'b1, 1'b0);
        #1 chk("accept_ready", 32'(readyOut), 32'd1);
        chk("read_index", 32'({readRegister1, readRegister2}), 32'({3'd2, 3'd5}));
        expect_out(8'h15, 8'h3A);
        tick();
        chk("latency_valid", 32'(validOut), 32'd1);
        issue(3'd3, 3'd7, 3'd2, 4'h4, 8'h12, 1'b0, 1'b0);
        #1 chk("b2b_ready1", 32'(readyOut), 32'd1);
        expect_out(8'h33, 8'h77);
        tick();
        issue(3'd0, 3'd1, 3'd3, 4'h6, 8'h80, 1'b1, 1'b0);
        #1 chk("b2b_ready2", 32'(readyOut), 32'd1);
        expect_out(8'h00, 8'h11);
        tick();
        validIn = 1'b0;
        tick();
        chk("bubble_valid", 32'(validOut), 32'd0);

        // Write-back to a source register in the accept cycle
        issue(3'd2, 3'd5, 3'd0, 4'h7, 8'h00, 1'b1, 1'b0);
        wbRegWrite = 1'b1; wbRegister = 3'd2; wbData = 8'h7F;
`ifdef OPERAND_FETCH_BYPASS_EN
        #1 chk("bypass_ready", 32'(readyOut), 32'd1);
        expect_out(8'h7F, 8'h3A);
        tick();
        wbRegWrite = 1'b0; validIn = 1'b0;
        chk("bypass_valid", 32'(validOut), 32'd1);
`else
        #1 chk("raw_stall_ready", 32'(readyOut), 32'd0);
        tick();
        wbRegWrite = 1'b0;
        chk("raw_bubble", 32'(validOut), 32'd0);
        #1 chk("raw_retry_ready", 32'(readyOut), 32'd1);
        expect_out(8'h7F, 8'h3A);
        tick();
        validIn = 1'b0;
        chk("raw_valid", 32'(validOut), 32'd1);
`endif
        tick();

        // Load-use interlock
        issue(3'd1, 3'd3, 3'd4, 4'h5, 8'h10, 1'b1, 1'b1);
        expect_out(8'h11, 8'h33);
        tick();
        issue(3'd0, 3'd4, 3'd5, 4'h2, 8'h20, 1'b1, 1'b0);
        #1 chk("load_use_ready", 32'(readyOut), 32'd0);
        tick();
        chk("load_use_bubble", 32'(validOut), 32'd0);
        #1 chk("load_use_retry", 32'(readyOut), 32'd1);
        expect_out(8'h00, 8'h44);
        tick();
        validIn = 1'b0;
        chk("load_use_valid", 32'(validOut), 32'd1);
        tick();
        // A load that does not write rd creates no hazard
        issue(3'd1, 3'd1, 3'd4, 4'h1, 8'h01, 1'b0, 1'b1);
        expect_out(8'h11, 8'h11);
        tick();
        issue(3'd4, 3'd0, 3'd0, 4'h0, 8'h02, 1'b0, 1'b0);
        #1 chk("no_hazard_ready", 32'(readyOut), 32'd1);
        expect_out(8'h44, 8'h00);
        tick();
        validIn = 1'b0;
        tick();

        // Hold with write-back refresh of operandA
        issue(3'd6, 3'd7, 3'd2, 4'h9, 8'hA5, 1'b1, 1'b0);
        expect_out(8'h99, 8'h77);
        tick();
        validIn = 1'b0; stallIn = 1'b1;
        #1 chk("hold_ready", 32'(readyOut), 32'd0);
        chk("hold_opa_before", 32'(operandA), 32'h66);
        tick();
        wbRegWrite = 1'b1; wbRegister = 3'd6; wbData = 8'h99;
        #1 chk("hold_opa_frozen", 32'(operandA), 32'h66);
        tick();
        wbRegWrite = 1'b0;
        chk("hold_opa_refresh", 32'(operandA), 32'h99);
        chk("hold_other", 32'({operandB, immOut, rdOut, rs1Out}), 32'({8'h77, 8'hA5, 3'd2, 3'd6}));
        chk("hold_valid", 32'(validOut), 32'd1);
        tick();
        stallIn = 1'b0;
        tick();
        chk("hold_release", 32'(validOut), 32'd0);

        // Flush during hold with an incoming instruction
        issue(3'd3, 3'd5, 3'd3, 4'h1, 8'h55, 1'b1, 1'b0);
        tick();
        validIn = 1'b0; stallIn = 1'b1;
        tick();
        flush = 1'b1;
        issue(3'd7, 3'd7, 3'd7, 4'hE, 8'hEE, 1'b1, 1'b0);
        #1 chk("flush_ready", 32'(readyOut), 32'd1);
        tick();
        flush = 1'b0; validIn = 1'b0; stallIn = 1'b0;
        chk("flush_valid", 32'(validOut), 32'd0);
        tick();
        chk("flush_dropped", 32'(validOut), 32'd0);

        // Reset while holding
        issue(3'd2, 3'd5, 3'd6, 4'hF, 8'hFF, 1'b1, 1'b1);
        tick();
        validIn = 1'b0; stallIn = 1'b1;
        tick();
        resetN = 1'b0;
        issue(3'd1, 3'd2, 3'd3, 4'h2, 8'h22, 1'b1, 1'b0);
        #1 chk("rst_hold_ready", 32'(readyOut), 32'd0);
        tick();
        chk("rst_hold_ctrl", 32'({validOut, regWriteOut, memReadOut, rdOut, rs1Out, rs2Out, opOut}), 32'd0);
        chk("rst_hold_data", 32'({operandA, operandB, immOut}), 32'd0);
        chk("rst_hold_ready2", 32'(readyOut), 32'd0);
        resetN = 1'b1; validIn = 1'b0; stallIn = 1'b0;
        #1 chk("rst_release_ready", 32'(readyOut), 32'd1);
        tick();
        chk("rst_release_valid", 32'(validOut), 32'd0);
        tick();
        tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
